// File: rtl/code_loader.sv
// Byte-stream code loader: packs little-endian bytes into 32-bit words and writes them to user code memory.
// Optional running checksum of written words is built when CODE_LOADER_CHECKSUM_EN is defined.
module code_loader #(
    parameter logic [31:0] USER_LIMIT = 32'h00004000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic [31:0] iBaseAddr,
    input  logic [12:0] iWordCount,
    input  logic        iByteValid,
    input  logic [7:0]  iByte,
    output logic        oByteReady,
    input  logic        iAbort,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError,
    output logic [31:0] oAddress,
    output logic [31:0] oWriteData,
    output logic        oMemWrite,
    output logic        oMemRead,
    output logic [31:0] oChecksum
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] addr_r;
    logic [12:0] remaining_r;
    logic [1:0]  byte_idx_r;
    logic [23:0] partial_r;
    logic [31:0] wdata_r;
    logic        ready_r;
    logic        busy_r;
    logic        done_r;
    logic        error_r;
    logic        mem_write_r;

    logic [33:0] end_addr_s;
    logic        start_bad_s;
    logic        byte_take_s;

    // Widened end address so a huge base plus count cannot wrap past the limit check.
    assign end_addr_s  = {2'b00, iBaseAddr} + {19'd0, iWordCount, 2'b00};
    assign start_bad_s = (iBaseAddr[1:0] != 2'b00) || (end_addr_s > {2'b00, USER_LIMIT});
    assign byte_take_s = ready_r & iByteValid;

    assign oByteReady = ready_r;
    assign oBusy      = busy_r;
    assign oDone      = done_r;
    assign oError     = error_r;
    assign oAddress   = addr_r;
    assign oWriteData = wdata_r;
    assign oMemWrite  = mem_write_r;
    assign oMemRead   = 1'b0;

    // Load sequencer: start validation, byte packing, single-cycle write, completion.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_r     <= IDLE;
            addr_r      <= 32'd0;
            remaining_r <= 13'd0;
            byte_idx_r  <= 2'd0;
            partial_r   <= 24'd0;
            wdata_r     <= 32'd0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            mem_write_r <= 1'b0;
        end else begin
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            mem_write_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (iStart) begin
                        if (start_bad_s) begin
                            error_r <= 1'b1;
                        end else if (iWordCount == 13'd0) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            addr_r      <= iBaseAddr;
                            remaining_r <= iWordCount;
                            byte_idx_r  <= 2'd0;
                            ready_r     <= 1'b1;
                            busy_r      <= 1'b1;
                            state_r     <= COLLECT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                COLLECT: begin
                    if (iAbort) begin
                        ready_r <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (byte_take_s) begin
                        byte_idx_r <= byte_idx_r + 2'd1;
                        case (byte_idx_r)
                            2'd0:    partial_r[7:0]   <= iByte;
                            2'd1:    partial_r[15:8]  <= iByte;
                            2'd2:    partial_r[23:16] <= iByte;
                            default: begin
                                wdata_r     <= {iByte, partial_r};
                                mem_write_r <= 1'b1;
                                ready_r     <= 1'b0;
                                state_r     <= WRITE;
                            end
                        endcase
                    end else begin
                        state_r <= COLLECT;
                    end
                end
                WRITE: begin
                    addr_r      <= addr_r + 32'd4;
                    remaining_r <= remaining_r - 13'd1;
                    if (iAbort) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (remaining_r == 13'd1) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= COLLECT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef CODE_LOADER_CHECKSUM_EN
    logic [31:0] checksum_r;

    // Running sum of written words, restarted by each accepted valid load request.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            checksum_r <= 32'd0;
        end else if ((state_r == IDLE) && iStart && !start_bad_s) begin
            checksum_r <= 32'd0;
        end else if (state_r == WRITE) begin
            checksum_r <= checksum_r + wdata_r;
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign oChecksum = checksum_r;
`else
    assign oChecksum = 32'd0;
`endif

endmodule

// File: tb/tb_code_loader.sv
// Directed self-checking bench for code_loader; expected checksums follow CODE_LOADER_CHECKSUM_EN.
module tb_code_loader;

`ifdef CODE_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        iCLK;
    logic        iRST;
    logic        iStart;
    logic [31:0] iBaseAddr;
    logic [12:0] iWordCount;
    logic        iByteValid;
    logic [7:0]  iByte;
    logic        oByteReady;
    logic        iAbort;
    logic        oBusy;
    logic        oDone;
    logic        oError;
    logic [31:0] oAddress;
    logic [31:0] oWriteData;
    logic        oMemWrite;
    logic        oMemRead;
    logic [31:0] oChecksum;

    code_loader dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iBaseAddr(iBaseAddr),
        .iWordCount(iWordCount), .iByteValid(iByteValid), .iByte(iByte),
        .oByteReady(oByteReady), .iAbort(iAbort), .oBusy(oBusy), .oDone(oDone),
        .oError(oError), .oAddress(oAddress), .oWriteData(oWriteData),
        .oMemWrite(oMemWrite), .oMemRead(oMemRead), .oChecksum(oChecksum)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int done_cnt = 0;
    int err_cnt  = 0;
    int busy_cnt = 0;

    // Passive monitor sampling away from the active edge.
    always @(negedge iCLK) begin
        if (oMemWrite) begin
            wr_addr.push_back(oAddress);
            wr_data.push_back(oWriteData);
        end
        if (oDone)  done_cnt++;
        if (oError) err_cnt++;
        if (oBusy)  busy_cnt++;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic start_load(input logic [31:0] base, input logic [12:0] count);
        iStart = 1'b1; iBaseAddr = base; iWordCount = count;
        @(negedge iCLK);
        iStart = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit taken;
        taken = 1'b0;
        iByteValid = 1'b1; iByte = b;
        for (int w = 0; w < 20 && !taken; w++) begin
            taken = oByteReady;
            @(negedge iCLK);
        end
        iByteValid = 1'b0;
        check_value("byte_accept", {31'd0, taken}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_ready"}, {31'd0, oByteReady}, 32'd0);
        check_value({tag, "_busy"},  {31'd0, oBusy}, 32'd0);
        check_value({tag, "_done"},  {31'd0, oDone}, 32'd0);
        check_value({tag, "_error"}, {31'd0, oError}, 32'd0);
        check_value({tag, "_mwr"},   {31'd0, oMemWrite}, 32'd0);
        check_value({tag, "_mrd"},   {31'd0, oMemRead}, 32'd0);
        check_value({tag, "_addr"},  oAddress, 32'd0);
        check_value({tag, "_wdata"}, oWriteData, 32'd0);
        check_value({tag, "_csum"},  oChecksum, 32'd0);
    endtask

    int w0, d0, e0, b0;
    logic [7:0] seq[8];

    task automatic snap();
        w0 = wr_addr.size(); d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
    endtask

    initial begin
        iRST = 1'b1; iStart = 1'b0; iBaseAddr = 32'd0; iWordCount = 13'd0;
        iByteValid = 1'b0; iByte = 8'd0; iAbort = 1'b0;
        repeat (3) @(negedge iCLK);
        check_reset_outputs("reset");
        iRST = 1'b0;
        @(negedge iCLK);

        // Two-word load at base 0 with latency check on the first write.
        snap();
        start_load(32'd0, 13'd2);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check_value("lat_mwr",   {31'd0, oMemWrite}, 32'd1);
        check_value("lat_addr",  oAddress, 32'd0);
        check_value("lat_data",  oWriteData, 32'h44332211);
        check_value("lat_ready", {31'd0, oByteReady}, 32'd0);
        check_value("lat_busy",  {31'd0, oBusy}, 32'd1);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        repeat (4) @(negedge iCLK);
        check_value("t2_nwr",  wr_addr.size() - w0, 32'd2);
        check_value("t2_a0",   wr_addr[w0], 32'd0);
        check_value("t2_d0",   wr_data[w0], 32'h44332211);
        check_value("t2_a1",   wr_addr[w0+1], 32'd4);
        check_value("t2_d1",   wr_data[w0+1], 32'h88776655);
        check_value("t2_done", done_cnt - d0, 32'd1);
        check_value("t2_csum", oChecksum, CSUM_ON ? 32'hCCAA8866 : 32'd0);
        check_value("t2_busy", {31'd0, oBusy}, 32'd0);

        // Last two words of the region: exactly fits the limit.
        snap();
        start_load(32'h00003FF8, 13'd2);
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
        repeat (4) @(negedge iCLK);
        check_value("edge_nwr",  wr_addr.size() - w0, 32'd2);
        check_value("edge_a1",   wr_addr[w0+1], 32'h00003FFC);
        check_value("edge_d1",   wr_data[w0+1], 32'h08070605);
        check_value("edge_err",  err_cnt - e0, 32'd0);
        check_value("edge_csum", oChecksum, CSUM_ON ? 32'h0C0A0806 : 32'd0);

        // Overrun of the region is rejected.
        snap();
        start_load(32'h00003FFC, 13'd2);
        repeat (4) @(negedge iCLK);
        check_value("ovr_err",  err_cnt - e0, 32'd1);
        check_value("ovr_nwr",  wr_addr.size() - w0, 32'd0);
        check_value("ovr_busy", busy_cnt - b0, 32'd0);

        // Misaligned base is rejected.
        snap();
        start_load(32'h00000002, 13'd1);
        repeat (4) @(negedge iCLK);
        check_value("mis_err", err_cnt - e0, 32'd1);
        check_value("mis_nwr", wr_addr.size() - w0, 32'd0);

        // Zero-word load completes immediately and clears the checksum.
        snap();
        start_load(32'd0, 13'd0);
        repeat (4) @(negedge iCLK);
        check_value("zero_done", done_cnt - d0, 32'd1);
        check_value("zero_nwr",  wr_addr.size() - w0, 32'd0);
        check_value("zero_err",  err_cnt - e0, 32'd0);
        check_value("zero_csum", oChecksum, 32'd0);

        // Abort mid-second-word, then a fresh load.
        snap();
        start_load(32'h00000100, 13'd3);
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
        iAbort = 1'b1;
        @(negedge iCLK);
        iAbort = 1'b0;
        repeat (4) @(negedge iCLK);
        check_value("abt_nwr",  wr_addr.size() - w0, 32'd1);
        check_value("abt_a0",   wr_addr[w0], 32'h00000100);
        check_value("abt_d0",   wr_data[w0], 32'hA3A2A1A0);
        check_value("abt_done", done_cnt - d0, 32'd0);
        check_value("abt_busy", {31'd0, oBusy}, 32'd0);
        snap();
        start_load(32'h00000200, 13'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        repeat (4) @(negedge iCLK);
        check_value("abt2_nwr",  wr_addr.size() - w0, 32'd1);
        check_value("abt2_a0",   wr_addr[w0], 32'h00000200);
        check_value("abt2_d0",   wr_data[w0], 32'h04030201);
        check_value("abt2_done", done_cnt - d0, 32'd1);

        // Asynchronous reset in the middle of collecting a word.
        snap();
        start_load(32'h00000300, 13'd1);
        send_byte(8'h5A); send_byte(8'hA5);
        #2 iRST = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);
        start_load(32'h00000040, 13'd1);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        repeat (4) @(negedge iCLK);
        check_value("rst_nwr",  wr_addr.size() - w0, 32'd1);
        check_value("rst_a0",   wr_addr[w0], 32'h00000040);
        check_value("rst_d0",   wr_data[w0], 32'hEFBEADDE);
        check_value("rst_csum", oChecksum, CSUM_ON ? 32'hEFBEADDE : 32'd0);

        // Gapped byte stream with repeated start requests while busy.
        snap();
        seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        start_load(32'h00000080, 13'd2);
        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                iStart = (g == 0); iBaseAddr = 32'd0; iWordCount = 13'd1;
                @(negedge iCLK);
            end
            iStart = 1'b0;
            send_byte(seq[i]);
        end
        repeat (4) @(negedge iCLK);
        check_value("gap_nwr",  wr_addr.size() - w0, 32'd2);
        check_value("gap_a0",   wr_addr[w0], 32'h00000080);
        check_value("gap_d0",   wr_data[w0], 32'h13121110);
        check_value("gap_a1",   wr_addr[w0+1], 32'h00000084);
        check_value("gap_d1",   wr_data[w0+1], 32'h17161514);
        check_value("gap_done", done_cnt - d0, 32'd1);
        check_value("gap_err",  err_cnt - e0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/code_loader.md
CODE_LOADER -- requirements
Module: code_loader

Interface
REQ-001 SHALL have parameter USER_LIMIT, default 32'h00004000, exclusive upper byte address of the user code region (4K x 32).
REQ-002 SHALL have port iCLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port iRST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports iStart input 1 (load request pulse), iBaseAddr input 32 (first byte address), iWordCount input 13 (words to load, 0..4096).
REQ-005 SHALL have ports iByteValid input 1, iByte input 8, oByteReady output 1 (byte stream; transfer when valid and ready both high at a clock edge).
REQ-006 SHALL have ports iAbort input 1 (cancel load), oBusy output 1, oDone output 1 (one-cycle completion pulse), oError output 1 (one-cycle rejection pulse).
REQ-007 SHALL have code memory master ports oAddress output 32, oWriteData output 32, oMemWrite output 1, oMemRead output 1.
REQ-008 SHALL have port oChecksum output 32 (sum of written words).

Function
REQ-009 SHALL implement states IDLE, COLLECT, WRITE, DONE.
REQ-010 IDLE: iStart accepted only in IDLE; iStart in any other state SHALL be ignored.
REQ-011 On accepted iStart, iBaseAddr[1:0] != 0 or iBaseAddr + 4*iWordCount > USER_LIMIT SHALL pulse oError next cycle, perform no writes, remain IDLE.
REQ-012 On accepted iStart with iWordCount = 0 and valid base, SHALL go to DONE with no writes.
REQ-013 Otherwise SHALL latch address = iBaseAddr, remaining = iWordCount, clear byte index, go to COLLECT.
REQ-014 COLLECT: oByteReady = 1; each accepted byte k (0..3) SHALL be placed in word bits [8k+7:8k] (little-endian).
REQ-015 Acceptance of byte 3 SHALL move to WRITE on the same edge.
REQ-016 WRITE: exactly one cycle, oMemWrite = 1, oAddress = current address, oWriteData = assembled word, oByteReady = 0.
REQ-017 Latency: byte 3 accepted at edge N SHALL give oMemWrite high during cycle N to N+1 (one cycle after acceptance).
REQ-018 After WRITE, address SHALL increment by 4 and remaining by 1; remaining reaching 0 SHALL go to DONE, else COLLECT.
REQ-019 DONE: oDone = 1 for exactly one cycle, then IDLE.
REQ-020 oBusy SHALL be 1 in COLLECT and WRITE, 0 in IDLE and DONE.
REQ-021 oMemRead SHALL be constant 0; oMemWrite SHALL be 0 outside WRITE.
REQ-022 iAbort in COLLECT SHALL discard partial word and go IDLE without oDone; iAbort in WRITE SHALL let the write complete, then go IDLE without oDone.
REQ-023 Bytes presented while oByteReady = 0 SHALL not be consumed.
REQ-024 Address arithmetic SHALL be 32-bit; no write SHALL ever target an address >= USER_LIMIT.

Reset
REQ-025 iRST SHALL force IDLE immediately, regardless of clock.
REQ-026 Reset values: oByteReady 0, oBusy 0, oDone 0, oError 0, oMemWrite 0, oMemRead 0, oAddress 0, oWriteData 0, oChecksum 0.
REQ-027 Reset during COLLECT or WRITE SHALL abandon the load; a write in progress SHALL be deasserted asynchronously.

Configuration
REQ-028 With macro CODE_LOADER_CHECKSUM_EN defined, oChecksum SHALL clear on accepted valid iStart and add each written word modulo 2^32 on the WRITE edge.
REQ-029 Without CODE_LOADER_CHECKSUM_EN, oChecksum SHALL be constant 0 and no checksum register SHALL exist.

Verification
REQ-030 Base 0, count 2, bytes 11 22 33 44 55 66 77 88 -> writes 32'h44332211 @0, 32'h88776655 @4, oDone once, checksum 32'hCCAA8866 (with macro).
REQ-031 Base 32'h00003FFC, count 2 -> oError pulse, zero writes, oBusy stays 0.
REQ-032 Base 32'h00000002, count 1 -> oError pulse; count 0 at base 0 -> oDone pulse, no writes.
REQ-033 Count 3, iAbort after 6 bytes -> exactly one write, no oDone, return to IDLE, new iStart accepted.
REQ-034 iRST asserted mid-COLLECT after 2 bytes -> all outputs at reset values immediately; following load of 1 word writes correctly.
REQ-035 Random iByteValid gaps, iStart repeated while busy -> ignored; write sequence and addresses unchanged.
